// File: rtl/axi_region_router.sv
// AXI4 slave that steers single-outstanding write/read bursts to NUM_PORTS simple memory ports by address region.
// Optional start-address alignment check: define AXI_ROUTER_ALIGN_CHECK_EN.
module axi_region_router #(
  parameter int                         DATA_W      = 256,
  parameter int                         ADDR_W      = 64,
  parameter int                         NUM_PORTS   = 4,
  parameter logic [NUM_PORTS*64-1:0]    REGION_BASE = '0,
  parameter logic [NUM_PORTS*64-1:0]    REGION_SIZE = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [ADDR_W-1:0]             s_awaddr,
  input  logic [7:0]                    s_awlen,
  input  logic [2:0]                    s_awsize,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  input  logic [DATA_W-1:0]             s_wdata,
  input  logic [DATA_W/8-1:0]           s_wstrb,
  input  logic                          s_wlast,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  output logic [1:0]                    s_bresp,
  input  logic                          s_arvalid,
  output logic                          s_arready,
  input  logic [ADDR_W-1:0]             s_araddr,
  input  logic [7:0]                    s_arlen,
  input  logic [2:0]                    s_arsize,
  output logic                          s_rvalid,
  input  logic                          s_rready,
  output logic [DATA_W-1:0]             s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  output logic [NUM_PORTS-1:0]          mem_we,
  output logic [ADDR_W-1:0]             mem_waddr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [DATA_W/8-1:0]           mem_wstrb,
  output logic [NUM_PORTS-1:0]          mem_re,
  output logic [ADDR_W-1:0]             mem_raddr,
  input  logic [NUM_PORTS*DATA_W-1:0]   mem_rdata
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WS = $clog2(DATA_W/8);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ISSUE = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;
  localparam logic [1:0] R_DATA  = 2'd3;

  // 65-bit compare so BASE+SIZE at the top of the address space cannot wrap
  function automatic logic in_region(input logic [ADDR_W-1:0] a, input logic [PW-1:0] p);
    logic [64:0] b, e, x;
    b = {1'b0, REGION_BASE[p*64 +: 64]};
    e = b + {1'b0, REGION_SIZE[p*64 +: 64]};
    x = 65'(a);
    return (x >= b) && (x < e);
  endfunction

  // {hit, index}; scanning downward lets the lowest matching index win
  function automatic logic [PW:0] decode(input logic [ADDR_W-1:0] a);
    logic [PW:0] r;
    r = '0;
    for (int i = NUM_PORTS-1; i >= 0; i--)
      if (in_region(a, PW'(i))) r = {1'b1, PW'(i)};
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a, input logic [PW-1:0] p);
    logic [64:0] off;
    off = 65'(a) - {1'b0, REGION_BASE[p*64 +: 64]};
    return ADDR_W'(off >> WS);
  endfunction

  logic [PW:0] aw_dec, ar_dec;
  logic        aw_mis, ar_mis;
  assign aw_dec = decode(s_awaddr);
  assign ar_dec = decode(s_araddr);

`ifdef AXI_ROUTER_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [ADDR_W-1:0] a, input logic [2:0] sz);
    return (a & ~({ADDR_W{1'b1}} << sz)) != '0;
  endfunction
  assign aw_mis = misaligned(s_awaddr, s_awsize);
  assign ar_mis = misaligned(s_araddr, s_arsize);
`else
  assign aw_mis = 1'b0;
  assign ar_mis = 1'b0;
`endif

  // ---------------- write path ----------------
  logic [1:0]        w_state;
  logic [ADDR_W-1:0] w_addr;
  logic [PW-1:0]     w_port;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic              w_go;
  logic [1:0]        w_resp;
  logic              w_in;

  assign w_in = in_region(w_addr, w_port);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_port  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_go    <= 1'b0;
      w_resp  <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: if (s_awvalid) begin
          w_state <= W_DATA;
          w_addr  <= s_awaddr;
          w_port  <= aw_dec[PW-1:0];
          w_len   <= s_awlen;
          w_size  <= s_awsize;
          w_cnt   <= '0;
          w_go    <= aw_dec[PW] && !aw_mis;
          w_resp  <= !aw_dec[PW] ? 2'b11 : (aw_mis ? 2'b10 : 2'b00);
        end
        W_DATA: if (s_wvalid) begin
          if (w_go && !w_in) w_resp <= 2'b10;
          w_addr <= w_addr + (ADDR_W'(1) << w_size);
          w_cnt  <= w_cnt + 8'd1;
          if (s_wlast || w_cnt == w_len) w_state <= W_RESP;
        end
        W_RESP: if (s_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign s_awready = (w_state == W_IDLE);
  assign s_wready  = (w_state == W_DATA);
  assign s_bvalid  = (w_state == W_RESP);
  assign s_bresp   = w_resp;
  assign mem_we    = (w_state == W_DATA && s_wvalid && w_go && w_in) ? (NUM_PORTS'(1) << w_port) : '0;
  assign mem_waddr = word_addr(w_addr, w_port);
  assign mem_wdata = s_wdata;
  assign mem_wstrb = s_wstrb;

  // ---------------- read path ----------------
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [PW-1:0]     r_port;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic              r_skip;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_in;

  assign r_in = in_region(r_addr, r_port);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_port  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_skip  <= 1'b0;
      r_data  <= '0;
      r_resp  <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: if (s_arvalid) begin
          r_addr <= s_araddr;
          r_port <= ar_dec[PW-1:0];
          r_len  <= s_arlen;
          r_size <= s_arsize;
          r_cnt  <= '0;
          r_skip <= !ar_dec[PW] || ar_mis;
          // error bursts go straight to data with zero payload for every beat
          if (!ar_dec[PW]) begin
            r_data  <= '0;
            r_resp  <= 2'b11;
            r_state <= R_DATA;
          end else if (ar_mis) begin
            r_data  <= '0;
            r_resp  <= 2'b10;
            r_state <= R_DATA;
          end else begin
            r_state <= R_ISSUE;
          end
        end
        R_ISSUE: r_state <= R_WAIT;
        R_WAIT: begin
          if (r_in) begin
            r_data <= mem_rdata[r_port*DATA_W +: DATA_W];
            r_resp <= 2'b00;
          end else begin
            r_data <= '0;
            r_resp <= 2'b10;
          end
          r_state <= R_DATA;
        end
        R_DATA: if (s_rready) begin
          r_addr <= r_addr + (ADDR_W'(1) << r_size);
          r_cnt  <= r_cnt + 8'd1;
          if (r_cnt == r_len)  r_state <= R_IDLE;
          else if (!r_skip)    r_state <= R_ISSUE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s_arready = (r_state == R_IDLE);
  assign s_rvalid  = (r_state == R_DATA);
  assign s_rlast   = (r_state == R_DATA) && (r_cnt == r_len);
  assign s_rdata   = r_data;
  assign s_rresp   = r_resp;
  assign mem_re    = (r_state == R_ISSUE && r_in) ? (NUM_PORTS'(1) << r_port) : '0;
  assign mem_raddr = word_addr(r_addr, r_port);

endmodule

// File: tb/tb_axi_region_router.sv
// Scoreboard bench for axi_region_router: two ports, port 1 at 0x1000..0x13FF, memory read data echoes word address.
module tb_axi_region_router;
  localparam int DW = 256;
  localparam int AW = 64;
  localparam int NP = 2;
  localparam logic [NP*64-1:0] BASE = {64'h1000, 64'h0};
  localparam logic [NP*64-1:0] SIZE = {64'h400, 64'h1000};

  logic clk, rst_n;
  logic s_awvalid, s_awready; logic [AW-1:0] s_awaddr; logic [7:0] s_awlen; logic [2:0] s_awsize;
  logic s_wvalid, s_wready; logic [DW-1:0] s_wdata; logic [DW/8-1:0] s_wstrb; logic s_wlast;
  logic s_bvalid, s_bready; logic [1:0] s_bresp;
  logic s_arvalid, s_arready; logic [AW-1:0] s_araddr; logic [7:0] s_arlen; logic [2:0] s_arsize;
  logic s_rvalid, s_rready; logic [DW-1:0] s_rdata; logic [1:0] s_rresp; logic s_rlast;
  logic [NP-1:0] mem_we, mem_re; logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata; logic [DW/8-1:0] mem_wstrb; logic [NP*DW-1:0] mem_rdata;

  axi_region_router #(.DATA_W(DW), .ADDR_W(AW), .NUM_PORTS(NP), .REGION_BASE(BASE), .REGION_SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int re_cnt   = 0;

  logic [NP-1:0] q_we_port[$]; logic [AW-1:0] q_we_addr[$]; logic [DW-1:0] q_we_data[$];
  logic [1:0]    q_b[$];
  logic [DW-1:0] q_rd[$]; logic [1:0] q_rr[$]; logic q_rl[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // memory model: one-cycle read latency, data = word address
  always @(posedge clk)
    for (int p = 0; p < NP; p++)
      if (mem_re[p]) mem_rdata[p*DW +: DW] <= DW'(mem_raddr);

  // monitor: compares every DUT-presented output against the queued expectation
  always @(negedge clk) begin
    re_cnt += $countones(mem_re);
    if (mem_we != '0) begin
      if (q_we_port.size() == 0) chk("spurious mem_we", 256'(mem_we), 256'(0));
      else begin
        chk("mem_we port", 256'(mem_we), 256'(q_we_port.pop_front()));
        chk("mem_waddr", 256'(mem_waddr), 256'(q_we_addr.pop_front()));
        chk("mem_wdata", mem_wdata, q_we_data.pop_front());
      end
    end
    if (s_bvalid && s_bready) begin
      if (q_b.size() == 0) chk("spurious bvalid", 256'(s_bvalid), 256'(0));
      else chk("bresp", 256'(s_bresp), 256'(q_b.pop_front()));
    end
    if (s_rvalid && s_rready) begin
      if (q_rd.size() == 0) chk("spurious rvalid", 256'(s_rvalid), 256'(0));
      else begin
        chk("rdata", s_rdata, q_rd.pop_front());
        chk("rresp", 256'(s_rresp), 256'(q_rr.pop_front()));
        chk("rlast", 256'(s_rlast), 256'(q_rl.pop_front()));
      end
    end
  end

  task automatic push_we(input logic [NP-1:0] p, input logic [AW-1:0] a, input logic [31:0] d);
    q_we_port.push_back(p); q_we_addr.push_back(a); q_we_data.push_back(DW'(d));
  endtask

  task automatic push_r(input logic [31:0] d, input logic [1:0] r, input logic l);
    q_rd.push_back(DW'(d)); q_rr.push_back(r); q_rl.push_back(l);
  endtask

  task automatic send_aw(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] sz);
    int t;
    t = 0;
    s_awvalid = 1'b1; s_awaddr = a; s_awlen = l; s_awsize = sz;
    @(negedge clk);
    while (!s_awready && t < 50) begin @(negedge clk); t++; end
    chk("awready", 256'(s_awready), 256'(1));
    @(posedge clk); #1 s_awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] sz);
    int t;
    t = 0;
    s_arvalid = 1'b1; s_araddr = a; s_arlen = l; s_arsize = sz;
    @(negedge clk);
    while (!s_arready && t < 50) begin @(negedge clk); t++; end
    chk("arready", 256'(s_arready), 256'(1));
    @(posedge clk); #1 s_arvalid = 1'b0;
  endtask

  task automatic send_w(input int n, input int last_at, input logic [31:0] tag);
    int t;
    for (int k = 0; k < n; k++) begin
      t = 0;
      s_wvalid = 1'b1; s_wdata = DW'(tag + 32'(k)); s_wlast = (k == last_at);
      @(negedge clk);
      while (!s_wready && t < 50) begin @(negedge clk); t++; end
      chk("wready", 256'(s_wready), 256'(1));
      @(posedge clk); #1;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q_we_port.size() + q_b.size() + q_rd.size()) != 0 && t < 300) begin @(posedge clk); t++; end
    chk("pending expectations", 256'(q_we_port.size() + q_b.size() + q_rd.size()), 256'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst awready", 256'(s_awready), 256'(1));
    chk("rst arready", 256'(s_arready), 256'(1));
    chk("rst wready", 256'(s_wready), 256'(0));
    chk("rst bvalid", 256'(s_bvalid), 256'(0));
    chk("rst rvalid", 256'(s_rvalid), 256'(0));
    chk("rst rlast", 256'(s_rlast), 256'(0));
    chk("rst rdata", s_rdata, 256'(0));
    chk("rst bresp", 256'(s_bresp), 256'(0));
    chk("rst rresp", 256'(s_rresp), 256'(0));
    chk("rst mem_we", 256'(mem_we), 256'(0));
    chk("rst mem_re", 256'(mem_re), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    s_awvalid = 0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
    s_wvalid = 0; s_wdata = '0; s_wstrb = '1; s_wlast = 0; s_bready = 1;
    s_arvalid = 0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_rready = 1;
    mem_rdata = '0;
    #12 chk_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 4-beat write into port 1, words 1..4
    for (int k = 0; k < 4; k++) push_we(2'b10, AW'(k + 1), 32'h100 + 32'(k));
    q_b.push_back(2'b00);
    send_aw(64'h1020, 8'd3, 3'd5); send_w(4, 3, 32'h100); drain();

    // early wlast ends the burst after two beats
    push_we(2'b10, 64'd0, 32'h200); push_we(2'b10, 64'd1, 32'h201); q_b.push_back(2'b00);
    send_aw(64'h1000, 8'd3, 3'd5); send_w(2, 1, 32'h200); drain();

    // port 0
    push_we(2'b01, 64'd2, 32'h300); q_b.push_back(2'b00);
    send_aw(64'h40, 8'd0, 3'd5); send_w(1, 0, 32'h300); drain();

    // unmapped write
    q_b.push_back(2'b11);
    send_aw(64'h9000, 8'd0, 3'd5); send_w(1, 0, 32'h350); drain();

    // second beat leaves region 1
    push_we(2'b10, 64'd31, 32'h400); q_b.push_back(2'b10);
    send_aw(64'h13E0, 8'd1, 3'd5); send_w(2, 1, 32'h400); drain();

    // misaligned start
`ifdef AXI_ROUTER_ALIGN_CHECK_EN
    q_b.push_back(2'b10);
`else
    push_we(2'b10, 64'd0, 32'h500); q_b.push_back(2'b00);
`endif
    send_aw(64'h1004, 8'd0, 3'd5); send_w(1, 0, 32'h500); drain();

    // 2-beat read with rready held low for 3 cycles on first beat
    push_r(32'd1, 2'b00, 1'b0); push_r(32'd2, 2'b00, 1'b1);
    s_rready = 1'b0;
    send_ar(64'h1020, 8'd1, 3'd5);
    t = 0;
    @(negedge clk);
    while (!s_rvalid && t < 50) begin @(negedge clk); t++; end
    chk("rvalid arrives", 256'(s_rvalid), 256'(1));
    for (int c = 0; c < 3; c++) begin
      chk("rdata held", s_rdata, 256'(1));
      chk("rvalid held", 256'(s_rvalid), 256'(1));
      if (c < 2) @(negedge clk);
    end
    @(posedge clk); #1 s_rready = 1'b1;
    drain();

    // unmapped read: three zero beats with DECERR
    push_r(32'd0, 2'b11, 1'b0); push_r(32'd0, 2'b11, 1'b0); push_r(32'd0, 2'b11, 1'b1);
    send_ar(64'h9000, 8'd2, 3'd5); drain();

    // read crossing out of region 1
    push_r(32'd31, 2'b00, 1'b0); push_r(32'd0, 2'b10, 1'b1);
    send_ar(64'h13E0, 8'd1, 3'd5); drain();
    chk("mem_re pulses", 256'(re_cnt), 256'(3));

    // reset during beat 2 of a write burst: no response afterwards
    push_we(2'b10, 64'd0, 32'h600); push_we(2'b10, 64'd1, 32'h601);
    send_aw(64'h1000, 8'd3, 3'd5); send_w(2, 3, 32'h600);
    s_wvalid = 1'b1; s_wdata = DW'(32'h602);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    s_wvalid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    push_we(2'b10, 64'd0, 32'h700); q_b.push_back(2'b00);
    send_aw(64'h1000, 8'd0, 3'd5); send_w(1, 0, 32'h700); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_region_router.md
AXI_REGION_ROUTER -- requirements
Module: axi_region_router

Interface
REQ-001 SHALL have parameter DATA_W, default 256, AXI data width in bits (power of two, 32..1024).
REQ-002 SHALL have parameter ADDR_W, default 64, AXI address width.
REQ-003 SHALL have parameter NUM_PORTS, default 4, memory ports (1..8).
REQ-004 SHALL have parameters REGION_BASE and REGION_SIZE, each NUM_PORTS*64 bits packed, default all zero; port i owns the byte range [BASE_i, BASE_i+SIZE_i).
REQ-005 SHALL have clk, input, 1, clock; rst_n, input, 1, reset (asynchronous, active-low).
REQ-006 SHALL have AXI slave AW: s_awvalid in 1, s_awready out 1, s_awaddr in ADDR_W, s_awlen in 8, s_awsize in 3.
REQ-007 SHALL have W: s_wvalid in 1, s_wready out 1, s_wdata in DATA_W, s_wstrb in DATA_W/8, s_wlast in 1; B: s_bvalid out 1, s_bready in 1, s_bresp out 2.
REQ-008 SHALL have AR: s_arvalid, s_arready, s_araddr, s_arlen, s_arsize (widths as AW); R: s_rvalid out 1, s_rready in 1, s_rdata out DATA_W, s_rresp out 2, s_rlast out 1.
REQ-009 SHALL have memory side: mem_we out NUM_PORTS, mem_waddr out ADDR_W, mem_wdata out DATA_W, mem_wstrb out DATA_W/8, mem_re out NUM_PORTS, mem_raddr out ADDR_W, mem_rdata in NUM_PORTS*DATA_W (valid exactly one cycle after mem_re).

Function
REQ-010 SHALL decode on AW/AR handshake: lowest index i with BASE_i <= addr < BASE_i+SIZE_i wins; no hit = unmapped.
REQ-011 SHALL run write FSM W_IDLE (awready=1) -> W_DATA (wready=1) -> W_RESP (bvalid=1) -> W_IDLE on bready; awready=0 outside W_IDLE.
REQ-012 SHALL, per W beat in W_DATA, pulse mem_we[i] for one cycle with mem_waddr = (addr-BASE_i) >> log2(DATA_W/8), wdata/wstrb passed through, then advance addr by 1<<awsize.
REQ-013 SHALL leave W_DATA on the beat with s_wlast=1 or after awlen+1 beats, whichever first; beats beyond count are not accepted.
REQ-014 SHALL run read FSM R_IDLE (arready=1) -> R_ISSUE (mem_re pulse) -> R_WAIT -> R_DATA (rvalid=1, rdata registered from mem_rdata slice i) -> R_ISSUE if beats remain else R_IDLE, on rready.
REQ-015 SHALL assert s_rlast only on beat arlen+1; read throughput is one beat per three cycles minimum; rdata/rresp stable while rvalid && !rready.
REQ-016 SHALL treat unmapped bursts: no mem_we/mem_re, W beats accepted and dropped, bresp=2'b11; each read beat rdata=0, rresp=2'b11, R_ISSUE/R_WAIT skipped.
REQ-017 SHALL, for a beat whose advanced address leaves the decoded region, suppress mem access; that read beat returns rdata=0, rresp=2'b10; the burst's bresp becomes 2'b10 unless DECERR.
REQ-018 SHALL return resp 2'b00 otherwise; write and read FSMs run independently and concurrently.

Reset
REQ-019 SHALL on rst_n low force W_IDLE, R_IDLE, awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, rdata=0, bresp=0, rresp=0, mem_we=0, mem_re=0 immediately.
REQ-020 SHALL abandon any burst in progress on reset with no response issued after release.

Configuration
REQ-021 SHALL, with AXI_ROUTER_ALIGN_CHECK_EN defined, flag a burst whose start address is not (1<<size)-aligned: no mem access, bresp=2'b10 / every rresp=2'b10, rdata=0.
REQ-022 SHALL, without AXI_ROUTER_ALIGN_CHECK_EN, ignore alignment; low address bits are truncated by the word shift.

Verification
REQ-023 NUM_PORTS=2, BASE1=0x1000 SIZE1=0x400; AW 0x1020 len=3 size=5, 4 beats -> mem_we[1] at words 1,2,3,4, bresp=0.
REQ-024 AR 0x1020 len=1 size=5, mem_rdata[1] echoes address -> two beats, rlast on second only, rresp=0, rready low 3 cycles holds rdata.
REQ-025 AW 0x9000 (unmapped) len=0 -> no mem_we, bresp=2'b11; AR 0x9000 len=2 -> three zero beats rresp=2'b11.
REQ-026 AR 0x13E0 len=1 size=5 in region 1 -> beat0 rresp=0, beat1 rresp=2'b10 rdata=0, one mem_re only.
REQ-027 rst_n low during W_DATA beat 2 -> all outputs at reset values same cycle, no bvalid afterwards, new AW accepted.
REQ-028 with AXI_ROUTER_ALIGN_CHECK_EN, AW 0x1004 size=5 -> no mem_we, bresp=2'b10; without it -> mem_we[1] word 0.
